dpsk_tx_sequencer: RTL and testbench

Frame sequencer for the DPSK transmit path. Accepts payload bytes over a valid/ready handshake and emits a preamble followed by the payload. The phase output is differentially encoded (1 bit per symbol) and held for a fixed number of sample ticks per symbol. It sits between the byte source and the phase-to-carrier mapper, and owns all symbol timing, framing and differential-encoder state.

---
 rtl/dpsk_tx_sequencer.sv | 122 ++++++++++++
 tb/tb_dpsk_tx_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dpsk_tx_sequencer.sv
// DPSK transmit frame sequencer: preamble of 1-bits followed by payload bytes MSB first,
// differentially encoded onto a 1-bit phase output held for SPS sample ticks per symbol.
module dpsk_tx_sequencer #(
    parameter int unsigned SPS           = 8,
    parameter int unsigned PREAMBLE_SYMS = 16
) (
    input  logic       clk,
    input  logic       r,
    input  logic       tick,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       phase,
    output logic       sym_strobe,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int unsigned SW = $clog2(SPS);
    // A single-symbol preamble would give a zero-width counter; keep at least one bit.
    localparam int unsigned PW = (PREAMBLE_SYMS > 1) ? $clog2(PREAMBLE_SYMS) : 1;
    localparam logic [SW-1:0] SAMP_LAST = SW'(SPS - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PREAMBLE_SYMS - 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

    state_t        state;
    logic [SW-1:0] samp_cnt;
    logic [PW-1:0] pre_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    data_q;
    logic          last_q;

    logic sym_end;
    logic pre_done;
    logic byte_end;
    logic refill;
    logic frame_end;

    always_comb begin
        sym_end   = (state != IDLE) && tick && (samp_cnt == SAMP_LAST);
        pre_done  = (state == PREAMBLE) && (pre_cnt == PRE_LAST);
        byte_end  = (state == DATA) && (bit_idx == 3'd0);
        refill    = sym_end && (pre_done || (byte_end && !last_q));
        frame_end = sym_end && byte_end && last_q;
        in_ready  = refill;
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state      <= IDLE;
            samp_cnt   <= '0;
            pre_cnt    <= '0;
            bit_idx    <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            phase      <= 1'b0;
            sym_strobe <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            sym_strobe <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                IDLE: begin
                    // Start does not consume the byte; it is taken at the end of the preamble.
                    if (in_valid) begin
                        state      <= PREAMBLE;
                        phase      <= 1'b1;
                        sym_strobe <= 1'b1;
                        samp_cnt   <= '0;
                        pre_cnt    <= '0;
                        bit_idx    <= '0;
                    end
                end
                PREAMBLE, DATA: begin
                    if (tick) begin
                        samp_cnt <= sym_end ? '0 : samp_cnt + SW'(1);
                    end
                    if (sym_end) begin
                        if (refill) begin
                            if (in_valid) begin
                                state      <= DATA;
                                data_q     <= in_data;
                                last_q     <= in_last;
                                bit_idx    <= 3'd7;
                                phase      <= phase ^ in_data[7];
                                sym_strobe <= 1'b1;
                            end else begin
                                state    <= IDLE;
                                phase    <= 1'b0;
                                underrun <= 1'b1;
                                pre_cnt  <= '0;
                                bit_idx  <= '0;
                            end
                        end else if (frame_end) begin
                            state   <= IDLE;
                            phase   <= 1'b0;
                            done    <= 1'b1;
                            pre_cnt <= '0;
                            bit_idx <= '0;
                        end else if (state == PREAMBLE) begin
                            pre_cnt    <= pre_cnt + PW'(1);
                            phase      <= ~phase;
                            sym_strobe <= 1'b1;
                        end else begin
                            bit_idx    <= bit_idx - 3'd1;
                            phase      <= phase ^ data_q[bit_idx - 3'd1];
                            sym_strobe <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpsk_tx_sequencer.sv
// Directed bench for dpsk_tx_sequencer (SPS=4, PREAMBLE_SYMS=2) with immediate-assertion checks.
module tb_dpsk_tx_sequencer;

    logic       clk = 1'b0;
    logic       r;
    logic       tick;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       phase;
    logic       sym_strobe;
    logic       busy;
    logic       done;
    logic       underrun;

    dpsk_tx_sequencer #(
        .SPS          (4),
        .PREAMBLE_SYMS(2)
    ) dut (
        .clk       (clk),
        .r         (r),
        .tick      (tick),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .phase     (phase),
        .sym_strobe(sym_strobe),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // Per-frame record filled by run_frame
    logic [31:0] seq;
    int          nstrobe;
    int          scyc[$];
    int          rdy_cyc[$];
    int          done_cyc;
    int          prev_done;
    int          bad;
    logic        got_done;
    logic        got_und;
    logic        fin_busy;
    logic        fin_phase;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at posedge+1. Sources up to two bytes; byte drop_at is withheld.
    task automatic run_frame(input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                             input int drop_at, input int tick_div, input int budget);
        int   idx;
        logic hs;
        logic [7:0] bytes [2];
        idx      = 0;
        bytes[0] = b0;
        bytes[1] = b1;
        seq      = '0;
        nstrobe  = 0;
        scyc.delete();
        rdy_cyc.delete();
        got_done  = 1'b0;
        got_und   = 1'b0;
        fin_busy  = 1'b1;
        fin_phase = 1'b1;
        done_cyc  = 0;
        for (int k = 0; k < budget; k++) begin
            #1;
            tick     = ((cyc % tick_div) == 0);
            in_valid = (idx < nbytes) && (idx != drop_at);
            in_data  = bytes[(idx < 2) ? idx : 0];
            in_last  = (idx == nbytes - 1);
            #1;
            if (in_ready) rdy_cyc.push_back(cyc);
            hs = in_ready && in_valid;
            step();
            if (hs) idx++;
            if (sym_strobe) begin
                seq = {seq[30:0], phase};
                nstrobe++;
                scyc.push_back(cyc);
            end
            if (done || underrun) begin
                got_done  = done;
                got_und   = underrun;
                fin_busy  = busy;
                fin_phase = phase;
                done_cyc  = cyc;
                in_valid  = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        r        = 1'b1;
        tick     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) step();
        check("reset_outputs", 32'({in_ready, phase, sym_strobe, busy, done, underrun}), 32'd0);
        r = 1'b0;
        step();

        // Single byte 0xA5, tick every cycle
        run_frame(1, 8'hA5, 8'h00, -1, 1, 200);
        check("t1_finished", 32'(got_done | got_und), 32'd1);
        check("t1_done", 32'(got_done), 32'd1);
        check("t1_nstrobe", 32'(nstrobe), 32'd10);
        check("t1_phases", seq, 32'h2C6);
        bad = 0;
        for (int i = 1; i < scyc.size(); i++) if (scyc[i] - scyc[i-1] != 4) bad++;
        check("t1_strobe_gaps", 32'(bad), 32'd0);
        check("t1_latency", 32'(done_cyc - scyc[0]), 32'd40);
        check("t1_idle_at_done", 32'({fin_busy, fin_phase}), 32'd0);
        prev_done = done_cyc;

        // Two bytes 0x00, 0xFF, started in the same cycle the previous done pulsed
        run_frame(2, 8'h00, 8'hFF, -1, 1, 300);
        check("t2_finished", 32'(got_done | got_und), 32'd1);
        check("t2_restart_gap", 32'(scyc[0] - prev_done), 32'd1);
        check("t2_done", 32'(got_done), 32'd1);
        check("t2_phases", seq, 32'h200AA);
        check("t2_rdy_count", 32'(rdy_cyc.size()), 32'd2);
        check("t2_rdy_preamble", 32'(rdy_cyc[0] - scyc[0]), 32'd7);
        check("t2_rdy_byte0", 32'(rdy_cyc[1] - scyc[0]), 32'd39);
        check("t2_latency", 32'(done_cyc - scyc[0]), 32'd72);

        // Underrun at second refill point
        repeat (2) step();
        run_frame(2, 8'h00, 8'hFF, 1, 1, 300);
        check("t3_finished", 32'(got_done | got_und), 32'd1);
        check("t3_underrun", 32'(got_und), 32'd1);
        check("t3_no_done", 32'(got_done), 32'd0);
        check("t3_idle_at_underrun", 32'({fin_busy, fin_phase}), 32'd0);
        check("t3_nstrobe", 32'(nstrobe), 32'd10);
        check("t3_phases", seq, 32'h200);
        check("t3_rdy_count", 32'(rdy_cyc.size()), 32'd2);
        repeat (5) step();
        check("t3_stay_idle", 32'({busy, done, phase}), 32'd0);

        // Tick every third cycle
        run_frame(1, 8'hA5, 8'h00, -1, 3, 600);
        check("t4_finished", 32'(got_done | got_und), 32'd1);
        check("t4_done", 32'(got_done), 32'd1);
        check("t4_nstrobe", 32'(nstrobe), 32'd10);
        check("t4_phases", seq, 32'h2C6);
        bad = 0;
        for (int i = 2; i < scyc.size(); i++) if (scyc[i] - scyc[i-1] != 12) bad++;
        check("t4_strobe_gaps", 32'(bad), 32'd0);
        check("t4_tail", 32'(done_cyc - scyc[scyc.size() - 1]), 32'd12);

        // Restart in the done cycle, then async reset mid-DATA
        tick     = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        in_last  = 1'b0;
        step();
        check("t5_restart", 32'({sym_strobe, phase, busy}), 32'b111);
        repeat (15) step();
        check("t5_in_data", 32'(busy), 32'd1);
        #3;
        r = 1'b1;
        #1;
        check("t5_async_reset", 32'({in_ready, phase, sym_strobe, busy, done, underrun}), 32'd0);
        in_valid = 1'b0;
        #2;
        r = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("t5_idle_%0d", i),
                  32'({in_ready, phase, sym_strobe, busy, done, underrun}), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
